// File: rtl/fxp_mult_seq.sv
// ---------------------------------------------------------------------------
// fxp_mult_seq
//
// Sequential Q7.8 signed multiplier. Operands are converted to sign-magnitude
// and multiplied with a shift-add loop (one multiplier bit per clock). The
// product magnitude, an 8-bit two's-complement view, the product sign and two
// overflow flags are handed to the downstream saturation/selection stage.
//
// Optional build macro: MULT_EARLY_EXIT_EN
//   undefined : always 15 shift-add iterations (16 cycles accept->out_valid)
//   defined   : the loop stops as soon as the remaining multiplier bits are all
//               zero; results are bit-identical, only latency changes.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both 1. A producer holds its data stable while valid is
// high and ready is low; valid is never withdrawn before the transfer.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   in_valid      operands a/b valid
//   in_ready      block can accept operands (high only in IDLE)
//   a, b          Q7.8 two's-complement multiplicand / multiplier
//   out_valid     product outputs valid
//   out_ready     downstream consumes the outputs
//   result        |a|*|b|, 16 fractional bits
//   signedResult  two's complement of result[22:15], modulo 256
//   sign          a[15] ^ b[15]
//   overflowHigh  OR of result[31:23]
//   overflowShift an operand equals 16'h8000 (magnitude not representable)
//   dbg_state     current FSM state, for observation only
// ---------------------------------------------------------------------------
module fxp_mult_seq #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [7:0]           signedResult,
  output logic                 sign,
  output logic                 overflowHigh,
  output logic                 overflowShift,
  output logic [1:0]           dbg_state
);

  // FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int MAG_W = WIDTH - 1;          // magnitude bits after sign strip
  localparam int ACC_W = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 2);

  // Product bit windows, derived from the fractional width.
  localparam int SR_LO = 2 * FRAC - 1;       // 15 for Q7.8
  localparam int SR_HI = 2 * FRAC + 6;       // 22 for Q7.8
  localparam int OV_LO = 2 * FRAC + 7;       // 23 for Q7.8

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [ACC_W-1:0] mcand;
  logic [MAG_W-1:0] mplr;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sign_w;
  logic             ovs_w;

  logic [ACC_W-1:0] acc_next;
  logic             last_iter;

  // Magnitude of a two's-complement value, truncated to MAG_W bits. The most
  // negative value wraps to 0 here; overflowShift flags that case.
  function automatic logic [MAG_W-1:0] mag(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] neg;
    neg = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    return x[WIDTH-1] ? neg[MAG_W-1:0] : x[MAG_W-1:0];
  endfunction

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;

  // One shift-add step: add the (already shifted) multiplicand when the
  // current multiplier LSB is set. 15x15 bits fits in 30, so no carry is lost.
  assign acc_next = acc + (mplr[0] ? mcand : {ACC_W{1'b0}});

`ifdef MULT_EARLY_EXIT_EN
  // Stop once no set multiplier bits remain after this step.
  assign last_iter = (cnt == LAST_ITER) || (mplr[MAG_W-1:1] == '0);
`else
  assign last_iter = (cnt == LAST_ITER);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      mcand         <= '0;
      mplr          <= '0;
      acc           <= '0;
      cnt           <= '0;
      sign_w        <= 1'b0;
      ovs_w         <= 1'b0;
      result        <= '0;
      signedResult  <= '0;
      sign          <= 1'b0;
      overflowHigh  <= 1'b0;
      overflowShift <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            state <= LOAD;
          end
        end

        LOAD: begin
          mcand  <= {{(ACC_W-MAG_W){1'b0}}, mag(a_q)};
          mplr   <= mag(b_q);
          // Sign and shift-overflow are held internally so the visible
          // outputs keep the previous product until the new one is ready.
          sign_w <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
          ovs_w  <= (a_q == MOST_NEG) || (b_q == MOST_NEG);
          acc    <= '0;
          cnt    <= '0;
          state  <= MUL;
        end

        MUL: begin
          acc   <= acc_next;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (last_iter) begin
            // All visible outputs update together on entry to DONE.
            result        <= acc_next;
            signedResult  <= ~acc_next[SR_HI:SR_LO] + 8'd1;
            overflowHigh  <= |acc_next[ACC_W-1:OV_LO];
            sign          <= sign_w;
            overflowShift <= ovs_w;
            out_valid     <= 1'b1;
            state         <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
